// File: rtl/per2axi_busy_tracker.sv
// ---------------------------------------------------------------------------
// per2axi_busy_tracker
//
// Outstanding-transaction tracker for the per2axi bridge. It counts write
// (AW -> B) and read (AR -> R) transactions in flight and gives:
//   * busy_o     : high while the tracker is not idle. It is held for IDLE_HOLD
//                  extra cycles after traffic drains, so clock gating does not
//                  chatter.
//   * aw/ar_stall: asserted at the outstanding limit of each channel, or while
//                  a flush is draining the bus.
//   * flush_ack_o: the drain is complete, meaning both counters are zero
//                  while the flush is still requested.
//
// Optional feature macro: PER2AXI_BUSY_ERR_EN
//   Defined   -> err_o exists. It is a sticky flag that is set on any
//                saturating increment, or on any decrement of a counter that
//                is already zero.
//   Undefined -> err_o and its logic are absent. Counter saturation and hold
//                behaviour is the same in both builds.
// ---------------------------------------------------------------------------
module per2axi_busy_tracker #(
  parameter int unsigned CNT_WIDTH    = 5,
  parameter int unsigned MAX_AW_OUTST = 16,
  parameter int unsigned MAX_AR_OUTST = 16,
  parameter int unsigned IDLE_HOLD    = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 aw_sync_i,
  input  logic                 b_sync_i,
  input  logic                 ar_sync_i,
  input  logic                 r_sync_i,
  input  logic                 flush_req_i,
  output logic                 flush_ack_o,
  output logic                 aw_stall_o,
  output logic                 ar_stall_o,
  output logic [CNT_WIDTH-1:0] aw_count_o,
  output logic [CNT_WIDTH-1:0] ar_count_o,
  output logic                 busy_o
`ifdef PER2AXI_BUSY_ERR_EN
  ,
  output logic                 err_o
`endif
);

  // -------------------------------------------------------------------------
  // Constants
  // -------------------------------------------------------------------------
  // The hold timer always needs at least one bit. This keeps the declarations
  // legal when IDLE_HOLD is 0; in that case the timer is never loaded.
  localparam int unsigned TMR_W = (IDLE_HOLD > 0) ? $clog2(IDLE_HOLD + 1) : 1;

  localparam logic [TMR_W-1:0] TMR_ONE   = TMR_W'(1);
  localparam logic [TMR_W-1:0] HOLD_LOAD = (IDLE_HOLD > 0) ? TMR_W'(IDLE_HOLD - 1) : '0;
  localparam logic             HOLD_EN   = (IDLE_HOLD > 0) ? 1'b1 : 1'b0;

  localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] CNT_ZERO = '0;
  localparam logic [CNT_WIDTH-1:0] CNT_MAX  = {CNT_WIDTH{1'b1}};
  localparam logic [CNT_WIDTH-1:0] AW_LIMIT = CNT_WIDTH'(MAX_AW_OUTST);
  localparam logic [CNT_WIDTH-1:0] AR_LIMIT = CNT_WIDTH'(MAX_AR_OUTST);

  // FSM encoding
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACTIVE = 2'd1;
  localparam logic [1:0] ST_HOLD   = 2'd2;
  localparam logic [1:0] ST_DRAIN  = 2'd3;

  // -------------------------------------------------------------------------
  // Helper functions
  // -------------------------------------------------------------------------
  // Next counter value. The counter saturates at both ends, so it never wraps.
  // An issue and a completion in the same cycle cancel each other.
  function automatic logic [CNT_WIDTH-1:0] cnt_step(
    input logic [CNT_WIDTH-1:0] cnt,
    input logic                 inc,
    input logic                 dec
  );
    logic [CNT_WIDTH-1:0] res;
    res = cnt;
    if (inc && !dec) begin
      if (cnt != CNT_MAX) begin
        res = cnt + CNT_ONE;
      end else begin
        res = cnt;
      end
    end else if (dec && !inc) begin
      if (cnt != CNT_ZERO) begin
        res = cnt - CNT_ONE;
      end else begin
        res = cnt;
      end
    end else begin
      res = cnt;
    end
    return res;
  endfunction

`ifdef PER2AXI_BUSY_ERR_EN
  // This is true when the pulse pair would push the counter past either end.
  function automatic logic cnt_fault(
    input logic [CNT_WIDTH-1:0] cnt,
    input logic                 inc,
    input logic                 dec
  );
    logic over;
    logic under;
    over  = inc && !dec && (cnt == CNT_MAX);
    under = dec && !inc && (cnt == CNT_ZERO);
    return over | under;
  endfunction
`endif

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  logic [CNT_WIDTH-1:0] aw_cnt_q, aw_cnt_d;
  logic [CNT_WIDTH-1:0] ar_cnt_q, ar_cnt_d;
  logic [1:0]           state_q, state_d;
  logic [TMR_W-1:0]     tmr_q, tmr_d;

  logic issue;        // any new transaction accepted this cycle
  logic cnt_zero_cur; // both counters are zero now
  logic cnt_zero_nxt; // both counters will be zero next cycle

  assign issue        = aw_sync_i | ar_sync_i;
  assign cnt_zero_cur = (aw_cnt_q == CNT_ZERO) && (ar_cnt_q == CNT_ZERO);
  assign cnt_zero_nxt = (aw_cnt_d == CNT_ZERO) && (ar_cnt_d == CNT_ZERO);

  // Next outstanding counts for the write and read channels.
  always_comb begin
    aw_cnt_d = cnt_step(aw_cnt_q, aw_sync_i, b_sync_i);
    ar_cnt_d = cnt_step(ar_cnt_q, ar_sync_i, r_sync_i);
  end

  // FSM next state and hold timer. A flush request overrides everything else.
  always_comb begin
    state_d = state_q;
    tmr_d   = tmr_q;
    if (flush_req_i) begin
      state_d = ST_DRAIN;
      tmr_d   = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (issue) begin
            state_d = ST_ACTIVE;
          end else begin
            state_d = ST_IDLE;
          end
          tmr_d = '0;
        end
        ST_ACTIVE: begin
          // Look ahead at the next counts. The hold window then starts in the
          // same cycle that the counters first read zero.
          if (cnt_zero_nxt) begin
            if (HOLD_EN) begin
              state_d = ST_HOLD;
              tmr_d   = HOLD_LOAD;
            end else begin
              state_d = ST_IDLE;
              tmr_d   = '0;
            end
          end else begin
            state_d = ST_ACTIVE;
            tmr_d   = '0;
          end
        end
        ST_HOLD: begin
          if (issue) begin
            state_d = ST_ACTIVE;
            tmr_d   = '0;
          end else if (tmr_q == '0) begin
            state_d = ST_IDLE;
            tmr_d   = '0;
          end else begin
            state_d = ST_HOLD;
            tmr_d   = tmr_q - TMR_ONE;
          end
        end
        ST_DRAIN: begin
          // The flush has been released here. Leave for IDLE only if the
          // bus has really gone quiet.
          if (cnt_zero_cur) begin
            state_d = ST_IDLE;
          end else begin
            state_d = ST_ACTIVE;
          end
          tmr_d = '0;
        end
        default: begin
          state_d = ST_IDLE;
          tmr_d   = '0;
        end
      endcase
    end
  end

  // Counter, FSM and timer registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      aw_cnt_q <= '0;
      ar_cnt_q <= '0;
      state_q  <= ST_IDLE;
      tmr_q    <= '0;
    end else begin
      aw_cnt_q <= aw_cnt_d;
      ar_cnt_q <= ar_cnt_d;
      state_q  <= state_d;
      tmr_q    <= tmr_d;
    end
  end

`ifdef PER2AXI_BUSY_ERR_EN
  logic err_q, err_d;

  // The error flag is sticky: once set, it stays set until reset.
  always_comb begin
    err_d = err_q
          | cnt_fault(aw_cnt_q, aw_sync_i, b_sync_i)
          | cnt_fault(ar_cnt_q, ar_sync_i, r_sync_i);
  end

  // Error flag register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign err_o = err_q;
`endif

  // -------------------------------------------------------------------------
  // Outputs: pure decodes of registered state, so nothing has to wait on
  // this cycle's pulses.
  // -------------------------------------------------------------------------
  assign aw_count_o  = aw_cnt_q;
  assign ar_count_o  = ar_cnt_q;
  assign busy_o      = (state_q != ST_IDLE);
  assign aw_stall_o  = (aw_cnt_q >= AW_LIMIT) || (state_q == ST_DRAIN);
  assign ar_stall_o  = (ar_cnt_q >= AR_LIMIT) || (state_q == ST_DRAIN);
  assign flush_ack_o = (state_q == ST_DRAIN) && cnt_zero_cur;

endmodule
